// File: rtl/stack_pkg.sv
// stack_pkg: shared op encoding and occupancy-width helper for lifo_stack
package stack_pkg;
   typedef enum logic [1:0] {
      OP_NONE = 2'b00,
      OP_POP  = 2'b01,
      OP_PUSH = 2'b10,
      OP_REPL = 2'b11
   } op_e;
   function automatic int cw_of(input int depth);
      return $clog2(depth + 1);
   endfunction
endpackage

// File: rtl/stack_cell.sv
// stack_cell: WIDTH-wide load-enable register with synchronous reset, one stack entry
module stack_cell #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_load,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);
   logic [WIDTH-1:0] r_q;
   // capture i_d when selected by the write decode
   always_ff @(posedge clk)
      if (reset) r_q <= '0;
      else if (i_load) r_q <= i_d;
   assign o_q = r_q;
endmodule

// File: rtl/lifo_stack.sv
// lifo_stack: register-slice LIFO with push/pop/replace-top; LIFO_ERR_STICKY_EN makes ovf/udf sticky
module lifo_stack
   import stack_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8,
   parameter int CW    = cw_of(DEPTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             empty,
   output logic             full,
   output logic [CW-1:0]    count,
   output logic             ovf,
   output logic             udf
);
   op_e              w_op;
   logic [CW-1:0]    r_sp;
   logic [CW-1:0]    w_sp_m1;
   logic             w_empty, w_full;
   logic             w_do_push, w_do_pop, w_do_repl;
   logic             w_ovf_ev, w_udf_ev;
   logic             r_ovf, r_udf;
   logic [DEPTH-1:0] w_load;
   logic [WIDTH-1:0] w_q [DEPTH];
   logic [WIDTH-1:0] w_dout;

   assign w_op      = op_e'({push, pop});
   assign w_sp_m1   = r_sp - CW'(1);
   assign w_empty   = r_sp == '0;
   assign w_full    = r_sp == CW'(DEPTH);
   assign w_do_push = w_op == OP_PUSH && !w_full;
   assign w_do_pop  = w_op == OP_POP && !w_empty;
   assign w_do_repl = w_op == OP_REPL && !w_empty;
   assign w_ovf_ev  = w_op == OP_PUSH && w_full;
   assign w_udf_ev  = w_op == OP_POP && w_empty;

   // push writes the slot above the top, replace-top rewrites the top slot
   genvar i;
   for (i = 0; i < DEPTH; i++) begin : g_cell
      assign w_load[i] = (w_do_push && r_sp == CW'(i)) || (w_do_repl && w_sp_m1 == CW'(i));
      stack_cell #(.WIDTH(WIDTH)) u_cell (
         .clk    (clk),
         .reset  (reset),
         .i_load (w_load[i]),
         .i_d    (din),
         .o_q    (w_q[i])
      );
   end

   // top-of-stack read mux, forced to zero when empty
   always_comb begin
      w_dout = '0;
      for (int k = 0; k < DEPTH; k++)
         if (!w_empty && w_sp_m1 == CW'(k)) w_dout = w_q[k];
   end

   // stack pointer: only accepted push/pop move it, replace-top and rejects hold
   always_ff @(posedge clk)
      if (reset) r_sp <= '0;
      else if (w_do_push) r_sp <= r_sp + CW'(1);
      else if (w_do_pop) r_sp <= w_sp_m1;

   // error flags for rejected operations
   always_ff @(posedge clk)
      if (reset) begin
         r_ovf <= 1'b0;
         r_udf <= 1'b0;
      end else begin
`ifdef LIFO_ERR_STICKY_EN
         r_ovf <= r_ovf | w_ovf_ev;
         r_udf <= r_udf | w_udf_ev;
`else
         r_ovf <= w_ovf_ev;
         r_udf <= w_udf_ev;
`endif
      end

   assign dout  = w_dout;
   assign empty = w_empty;
   assign full  = w_full;
   assign count = r_sp;
   assign ovf   = r_ovf;
   assign udf   = r_udf;
endmodule

// File: tb/tb_lifo_stack.sv
// tb_lifo_stack: directed and random stimulus against a queue-based LIFO model
module tb_lifo_stack;
   localparam int WIDTH = 8;
   localparam int DEPTH = 4;
   localparam int CW    = $clog2(DEPTH + 1);

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic             push = 1'b0;
   logic             pop = 1'b0;
   logic [WIDTH-1:0] din = '0;
   logic [WIDTH-1:0] dout;
   logic             empty, full, ovf, udf;
   logic [CW-1:0]    count;

   int n_cmp = 0;
   int n_err = 0;

   logic [WIDTH-1:0] m_q[$];
   logic             m_ovf = 1'b0;
   logic             m_udf = 1'b0;

   lifo_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .pop   (pop),
      .din   (din),
      .dout  (dout),
      .empty (empty),
      .full  (full),
      .count (count),
      .ovf   (ovf),
      .udf   (udf)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic step(input string tag, input logic rst, input logic p, input logic q, input logic [WIDTH-1:0] d);
      logic eo, eu;
      reset = rst; push = p; pop = q; din = d;
      @(posedge clk);
      if (rst) begin
         m_q.delete();
         m_ovf = 1'b0;
         m_udf = 1'b0;
      end else begin
         eo = p && !q && m_q.size() == DEPTH;
         eu = q && !p && m_q.size() == 0;
`ifdef LIFO_ERR_STICKY_EN
         m_ovf = m_ovf | eo;
         m_udf = m_udf | eu;
`else
         m_ovf = eo;
         m_udf = eu;
`endif
         if (p && q) begin
            if (m_q.size() > 0) m_q[m_q.size()-1] = d;
         end else if (p) begin
            if (m_q.size() < DEPTH) m_q.push_back(d);
         end else if (q) begin
            if (m_q.size() > 0) void'(m_q.pop_back());
         end
      end
      #1;
      check({tag, ".count"}, 32'(count), 32'(m_q.size()));
      check({tag, ".dout"}, 32'(dout), m_q.size() > 0 ? 32'(m_q[m_q.size()-1]) : 32'h0);
      check({tag, ".empty"}, 32'(empty), 32'(m_q.size() == 0));
      check({tag, ".full"}, 32'(full), 32'(m_q.size() == DEPTH));
      check({tag, ".ovf"}, 32'(ovf), 32'(m_ovf));
      check({tag, ".udf"}, 32'(udf), 32'(m_udf));
   endtask

   initial begin
      step("rst", 1, 0, 0, 8'h00);
      step("rst", 1, 0, 0, 8'h00);
      for (int k = 0; k < 3; k++) step("idle", 0, 0, 0, 8'h00);
      check("rst_dout_lit", 32'(dout), 32'h0);
      check("rst_empty_lit", 32'(empty), 32'h1);
      for (int k = 0; k < 4; k++) step("fill", 0, 1, 0, 8'(8'h11 * (k + 1)));
      check("full_lit", 32'(full), 32'h1);
      check("top44_lit", 32'(dout), 32'h44);
      for (int k = 0; k < 4; k++) step("drain", 0, 0, 1, 8'h00);
      check("drained_lit", 32'(empty), 32'h1);
      for (int k = 0; k < 4; k++) step("refill", 0, 1, 0, 8'(8'h11 * (k + 1)));
      step("ovf", 0, 1, 0, 8'h55);
      check("ovf_lit", 32'(ovf), 32'h1);
      check("ovf_dout_lit", 32'(dout), 32'h44);
      step("ovf_after", 0, 0, 0, 8'h00);
      step("rst2", 1, 0, 0, 8'h00);
      step("udf", 0, 0, 1, 8'h00);
      check("udf_lit", 32'(udf), 32'h1);
      step("udf_after", 0, 0, 0, 8'h00);
      step("rst3", 1, 0, 0, 8'h00);
      step("a0", 0, 1, 0, 8'hA0);
      step("a1", 0, 1, 0, 8'hA1);
      step("repl", 0, 1, 1, 8'hBB);
      check("repl_lit", 32'(dout), 32'hBB);
      step("repl_pop", 0, 0, 1, 8'h00);
      check("repl_pop_lit", 32'(dout), 32'hA0);
      for (int k = 0; k < 3; k++) step("fill2", 0, 1, 0, 8'(8'hC0 + k));
      step("repl_full", 0, 1, 1, 8'hDD);
      check("repl_full_dout_lit", 32'(dout), 32'hDD);
      step("rst4", 1, 0, 0, 8'h00);
      step("repl_empty", 0, 1, 1, 8'h77);
      check("repl_empty_dout_lit", 32'(dout), 32'h0);
      for (int k = 0; k < 3; k++) step("three", 0, 1, 0, 8'(8'h90 + k));
      step("rst_push", 1, 1, 0, 8'h99);
      check("rst_push_lit", 32'(count), 32'h0);
      for (int k = 0; k < 400; k++) begin
         logic [1:0] r;
         r = 2'($urandom_range(0, 3));
         step("rnd", $urandom_range(0, 39) == 0, r[1], r[0], 8'($urandom));
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
